// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, host-loadable instruction memory,
// next-PC selection and IDLE/RUN/HALT run control.
module instr_fetch_unit #(
  parameter int Instruction_Width = 32,
  parameter int Mem_Depth         = 64,
  parameter int Addr_Width        = $clog2(Mem_Depth)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         Start,
  input  logic                         Load_En,
  input  logic [Addr_Width-1:0]        Load_Addr,
  input  logic [Instruction_Width-1:0] Load_Data,
  input  logic                         JMP,
  input  logic                         PCSrc,
  output logic [Instruction_Width-1:0] Instruction,
  output logic [Instruction_Width-1:0] PC,
  output logic [Instruction_Width-1:0] PC_Plus4,
  output logic                         Running,
  output logic                         Halted,
  output logic [Instruction_Width-1:0] Instr_Count
);

  localparam int W = Instruction_Width;
  localparam logic [W-1:0] PcLimit = W'(4 * Mem_Depth);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] mem [Mem_Depth];

  logic [W-1:0] pc, pc_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] pc_p4;
  logic [W-1:0] br_off;
  logic [W-1:0] jmp_tgt;
  logic [W-1:0] seq_tgt;
  logic [W-1:0] fetch_tgt;
  logic [Addr_Width-1:0] widx;
  logic in_range;
  logic run_q, halt_q;

  assign pc_p4    = pc + W'(4);
  assign widx     = pc[Addr_Width+1:2];
  assign in_range = pc < PcLimit;

  // Outside RUN or past the end of memory the core sees an sll $0 NOP.
  assign Instruction = (state == RUN && in_range) ? mem[widx] : '0;

  assign br_off = {{(W-18){Instruction[15]}}, Instruction[15:0], 2'b00};
  assign jmp_tgt = {pc_p4[W-1:W-4], Instruction[25:0], 2'b00};
  assign seq_tgt = PCSrc ? pc_p4 + br_off : pc_p4;
  assign fetch_tgt = JMP ? jmp_tgt : seq_tgt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (cnt != '1) cnt_nxt = cnt + W'(1);
        // A jump onto itself is the end-of-program marker.
        if (JMP && jmp_tgt == pc) begin
          state_nxt = HALT;
        end else begin
          pc_nxt = fetch_tgt;
          if (fetch_tgt >= PcLimit) state_nxt = HALT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      pc     <= '0;
      cnt    <= '0;
      run_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      run_q  <= (state_nxt == RUN);
      halt_q <= (state_nxt == HALT);
    end
  end

  // Memory has no reset so a program survives RST.
  always_ff @(posedge CLK) begin
    if (!RST && Load_En && state == IDLE)
      mem[Load_Addr] <= Load_Data;
  end

  assign PC          = pc;
  assign PC_Plus4    = pc_p4;
  assign Running     = run_q;
  assign Halted      = halt_q;
  assign Instr_Count = cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random
// run against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic        Load_En;
  logic [5:0]  Load_Addr;
  logic [31:0] Load_Data;
  logic        JMP;
  logic        PCSrc;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic        Running;
  logic        Halted;
  logic [31:0] Instr_Count;

  int n_chk  = 0;
  int n_fail = 0;

  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_mem [64];

  instr_fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .Load_En    (Load_En),
    .Load_Addr  (Load_Addr),
    .Load_Data  (Load_Data),
    .JMP        (JMP),
    .PCSrc      (PCSrc),
    .Instruction(Instruction),
    .PC         (PC),
    .PC_Plus4   (PC_Plus4),
    .Running    (Running),
    .Halted     (Halted),
    .Instr_Count(Instr_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] m_instr();
    if (m_state == S_RUN && m_pc < 32'd256)
      return m_mem[m_pc[7:2]];
    return 32'h0;
  endfunction

  task automatic model_edge(input logic rst, input logic st,
                            input logic ld, input logic [5:0] la,
                            input logic [31:0] ldd,
                            input logic j, input logic ps);
    logic [31:0] ins, p4, nxt;
    int off;
    if (rst) begin
      m_state = S_IDLE;
      m_pc = 0;
      m_cnt = 0;
      return;
    end
    if (m_state == S_IDLE && ld) m_mem[la] = ldd;
    if (m_state == S_RUN) begin
      ins = m_instr();
      p4 = m_pc + 4;
      off = $signed(ins[15:0]);
      if (j)
        nxt = (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      else if (ps)
        nxt = p4 + 32'(off * 4);
      else
        nxt = p4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (j && nxt == m_pc) begin
        m_state = S_HALT;
      end else begin
        m_pc = nxt;
        if (m_pc >= 32'd256) m_state = S_HALT;
      end
    end else if (st) begin
      m_state = S_RUN;
      m_pc = 0;
      m_cnt = 0;
    end
  endtask

  // Drive one cycle of inputs from the falling edge, track the model
  // at the rising edge, and return at the next falling edge.
  task automatic cyc(input logic rst, input logic st,
                     input logic ld, input logic [5:0] la,
                     input logic [31:0] ldd,
                     input logic j, input logic ps);
    RST = rst;
    Start = st;
    Load_En = ld;
    Load_Addr = la;
    Load_Data = ldd;
    JMP = j;
    PCSrc = ps;
    @(posedge CLK);
    model_edge(rst, st, ld, la, ldd, j, ps);
    @(negedge CLK);
    RST = 0;
    Start = 0;
    Load_En = 0;
    JMP = 0;
    PCSrc = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want 0", PC);
    end
    n_chk++;
    if (PC_Plus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_pc4: got %h want 4", PC_Plus4);
    end
    n_chk++;
    if (Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got %h want 0", Instruction);
    end
    n_chk++;
    if (Running !== 1'b0 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got run=%b halt=%b want 0 0",
               Running, Halted);
    end
    n_chk++;
    if (Instr_Count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h want 0", Instr_Count);
    end
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 6'(i), 32'h0, 0, 0);
  endtask

  task automatic test_load_seq();
    logic [31:0] w [4];
    w[0] = 32'h2008_0005;
    w[1] = 32'h2009_0003;
    w[2] = 32'h0109_5020;
    w[3] = 32'h0109_582A;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 6'(i), w[i], 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (PC !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL seq_pc %0d: got %h want %h", i, PC, 32'(4 * i));
      end
      n_chk++;
      if (Instruction !== w[i] || Running !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_instr %0d: got %h run=%b want %h run=1",
                 i, Instruction, Running, w[i]);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    n_chk++;
    if (Instr_Count !== 32'd4 || PC !== 32'h10) begin
      n_fail++;
      $display("FAIL seq_cnt: got cnt=%0d pc=%h want 4 10",
               Instr_Count, PC);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++;
    if (PC !== 32'h14 || Instr_Count !== 32'd5) begin
      n_fail++;
      $display("FAIL start_in_run: got pc=%h cnt=%0d want 14 5",
               PC, Instr_Count);
    end
  endtask

  task automatic test_branch();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 6'd1, 32'h1109_0002, 0, 0);
    cyc(0, 0, 1, 6'd4, 32'h1000_FFFF, 0, 0);
    cyc(0, 0, 1, 6'd5, 32'h0800_0010, 0, 0);
    cyc(0, 1, 1, 6'd16, 32'h0800_0010, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (PC !== 32'h8) begin
      n_fail++;
      $display("FAIL br_not_taken: got %h want 8", PC);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (Instruction !== 32'h1109_0002) begin
      n_fail++;
      $display("FAIL br_instr: got %h want 11090002", Instruction);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (PC !== 32'h10) begin
      n_fail++;
      $display("FAIL br_taken: got %h want 10", PC);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (PC !== 32'h10 || Running !== 1'b1) begin
      n_fail++;
      $display("FAIL br_neg: got pc=%h run=%b want 10 1", PC, Running);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump_halt();
    n_chk++;
    if (PC !== 32'h14) begin
      n_fail++;
      $display("FAIL jmp_start_pc: got %h want 14", PC);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_chk++;
    if (PC !== 32'h40 || Instruction !== 32'h0800_0010) begin
      n_fail++;
      $display("FAIL jmp_wins: got pc=%h ins=%h want 40 08000010",
               PC, Instruction);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_chk++;
    if (Halted !== 1'b1 || Running !== 1'b0) begin
      n_fail++;
      $display("FAIL self_halt_flags: got halt=%b run=%b want 1 0",
               Halted, Running);
    end
    n_chk++;
    if (PC !== 32'h40 || Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL self_halt_pc: got pc=%h ins=%h want 40 0",
               PC, Instruction);
    end
    n_chk++;
    if (Instr_Count !== 32'd6) begin
      n_fail++;
      $display("FAIL self_halt_cnt: got %0d want 6", Instr_Count);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_chk++;
    if (PC !== 32'h40 || Instr_Count !== 32'd6) begin
      n_fail++;
      $display("FAIL halt_frozen: got pc=%h cnt=%0d want 40 6",
               PC, Instr_Count);
    end
  endtask

  task automatic test_range_restart();
    int n;
    cyc(0, 1, 0, 0, 0, 0, 0);
    n = 0;
    while (Halted !== 1'b1 && n < 80) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    n_chk++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL range_edges: got %0d want 64", n);
    end
    n_chk++;
    if (PC !== 32'h100 || Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL range_pc: got pc=%h ins=%h want 100 0",
               PC, Instruction);
    end
    n_chk++;
    if (Instr_Count !== 32'd64 || Running !== 1'b0) begin
      n_fail++;
      $display("FAIL range_cnt: got cnt=%0d run=%b want 64 0",
               Instr_Count, Running);
    end
    cyc(0, 0, 1, 6'd0, 32'hDEAD_BEEF, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++;
    if (PC !== 32'h0 || Instr_Count !== 32'h0 || Running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: got pc=%h cnt=%0d run=%b want 0 0 1",
               PC, Instr_Count, Running);
    end
    n_chk++;
    if (Instruction !== 32'h2008_0005) begin
      n_fail++;
      $display("FAIL halt_load_ignored: got %h want 20080005",
               Instruction);
    end
  endtask

  task automatic test_reset_mid_run();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (PC !== 32'h8) begin
      n_fail++;
      $display("FAIL rmid_pre: got %h want 8", PC);
    end
    cyc(1, 1, 0, 0, 0, 1, 1);
    n_chk++;
    if (PC !== 32'h0 || PC_Plus4 !== 32'h4 || Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_pc: got pc=%h p4=%h ins=%h want 0 4 0",
               PC, PC_Plus4, Instruction);
    end
    n_chk++;
    if (Running !== 0 || Halted !== 0 || Instr_Count !== 0) begin
      n_fail++;
      $display("FAIL rmid_state: got run=%b halt=%b cnt=%0d want 0 0 0",
               Running, Halted, Instr_Count);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++;
    if (Instruction !== 32'h2008_0005) begin
      n_fail++;
      $display("FAIL rmid_mem: got %h want 20080005", Instruction);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 6'd0, 32'hA5A5_0001, 0, 0);
    n_chk++;
    if (Instruction !== 32'hA5A5_0001 || Running !== 1'b1) begin
      n_fail++;
      $display("FAIL load_start: got %h run=%b want a5a50001 1",
               Instruction, Running);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1, 0) == 0) w[25:6] = '0;
    else if ($urandom_range(1, 0) == 0) w[15:6] = '1;
    return w;
  endfunction

  task automatic test_random();
    logic st, ld, j, ps, r;
    logic [5:0] la;
    logic [31:0] ldd;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 6'(i), rnd_word(), 0, 0);
    for (int c = 0; c < 800; c++) begin
      r   = ($urandom_range(99, 0) == 0);
      st  = ($urandom_range(7, 0) == 0);
      ld  = ($urandom_range(5, 0) == 0);
      la  = 6'($urandom);
      ldd = rnd_word();
      j   = ($urandom_range(7, 0) == 0);
      ps  = ($urandom_range(3, 0) == 0);
      cyc(r, st, ld, la, ldd, j, ps);
      n_chk++;
      if (PC !== m_pc) begin
        n_fail++;
        $display("FAIL rnd_pc %0d: got %h want %h", c, PC, m_pc);
      end
      n_chk++;
      if (PC_Plus4 !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL rnd_pc4 %0d: got %h want %h",
                 c, PC_Plus4, m_pc + 32'd4);
      end
      n_chk++;
      if (Instruction !== m_instr()) begin
        n_fail++;
        $display("FAIL rnd_instr %0d: got %h want %h",
                 c, Instruction, m_instr());
      end
      n_chk++;
      if (Running !== (m_state == S_RUN)) begin
        n_fail++;
        $display("FAIL rnd_run %0d: got %b want %b",
                 c, Running, m_state == S_RUN);
      end
      n_chk++;
      if (Halted !== (m_state == S_HALT)) begin
        n_fail++;
        $display("FAIL rnd_halt %0d: got %b want %b",
                 c, Halted, m_state == S_HALT);
      end
      n_chk++;
      if (Instr_Count !== m_cnt) begin
        n_fail++;
        $display("FAIL rnd_cnt %0d: got %0d want %0d",
                 c, Instr_Count, m_cnt);
      end
    end
  endtask

  initial begin
    RST = 1;
    Start = 0;
    Load_En = 0;
    Load_Addr = 0;
    Load_Data = 0;
    JMP = 0;
    PCSrc = 0;
    m_state = S_IDLE;
    m_pc = 0;
    m_cnt = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 0;
    @(negedge CLK);
    test_reset();
    test_load_seq();
    test_branch();
    test_jump_halt();
    test_range_restart();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-cycle MIPS core. It holds the program counter and a word-addressed instruction memory that a host loads before the program starts. It presents the current 32-bit instruction to the control unit and computes the next PC from that unit's JMP and PCSrc outputs. A small run-control state machine (IDLE/RUN/HALT) gates fetching, detects end of program and counts executed instructions.

## Interface
Parameters:
- Instruction_Width, 32, instruction and PC width.
- Mem_Depth, 64, instruction memory depth in 32-bit words.
- Addr_Width, $clog2(Mem_Depth), word address width of the load port.

Ports:
- CLK  input  1  core clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse: IDLE→RUN or HALT→RUN.
- Load_En  input  1  memory write strobe; honoured in IDLE only.
- Load_Addr  input  Addr_Width  word address of the load write.
- Load_Data  input  32  instruction word to write.
- JMP  input  1  jump select from the control unit.
- PCSrc  input  1  taken-branch select (Branch & Zero) from the control unit.
- Instruction  output  32  current instruction to the control unit and datapath.
- PC  output  32  current program counter (byte address).
- PC_Plus4  output  32  PC + 4.
- Running  output  1  high in RUN.
- Halted  output  1  high in HALT.
- Instr_Count  output  32  instructions executed since the last start.

## Operation
- States:
  - IDLE is entered after reset. PC is held and the memory can be loaded.
  - RUN: fetch and update PC every cycle.
  - HALT: PC is frozen at its final value.
- Load: in IDLE, Load_En writes Load_Data into mem[Load_Addr] at the edge. Load_En in RUN or HALT is ignored. Memory contents are not cleared by RST.
- Instruction = mem[PC[Addr_Width+1:2]] (asynchronous read) when in RUN and the word index is < Mem_Depth. Otherwise it is 32'h0000_0000, an sll $0 NOP.
- Next PC in RUN, with JMP having priority over PCSrc:
  - JMP=1: {PC_Plus4[31:28], Instruction[25:0], 2'b00}.
  - else PCSrc=1: PC_Plus4 + {sign-extended Instruction[15:0], 2'b00}, 32-bit wrap, no overflow flag.
  - else: PC_Plus4.
- Transitions:
  - IDLE + Start: RUN. PC ← 0, Instr_Count ← 0.
  - RUN + JMP=1 and jump target == PC (jump-to-self): HALT. PC is unchanged and this instruction is counted.
  - RUN + next-PC word index ≥ Mem_Depth, or next PC ≥ 4·Mem_Depth: PC takes the next-PC value, then HALT.
  - HALT + Start: RUN. PC ← 0, Instr_Count ← 0.
  - Start in RUN is ignored.
- Instr_Count increments by 1 on every RUN-cycle edge. It saturates at 32'hFFFF_FFFF.
- Load_En and Start in the same IDLE cycle: the write completes and the state becomes RUN. The first fetch sees the written data.

## Timing
- Reset values: PC = 0, PC_Plus4 = 4, Instruction = 0, Running = 0, Halted = 0, Instr_Count = 0, state IDLE.
- RST has priority over every other input. Asserted mid-RUN, the next edge gives IDLE with all outputs at reset values. Memory is retained.
- Instruction, PC_Plus4 and the next-PC mux are combinational from PC. The control unit's JMP and PCSrc must settle in the same cycle.
- PC latency: one edge from the decision to the new PC.
- Running and Halted are registered. Both reflect the state after the edge.
- Start→first fetch: the edge where Start=1 is sampled loads PC=0. Instruction mem[0] is valid in the following cycle.

## Test plan
- Load and sequential fetch:
  - Stimulus: load words 0–3 = 0x20080005, 0x20090003, 0x01095020, 0x0109582A, then pulse Start.
  - Required: PC = 0x0, 0x4, 0x8, 0xC on consecutive cycles, Instruction matches each word, Instr_Count = 4 after four RUN edges.
- Branch taken:
  - Stimulus: at PC = 0x4, Instruction = 0x11090002 and PCSrc = 1.
  - Required: next PC = 0x10. With PCSrc = 0 the next PC is 0x8. A negative offset of 0xFFFF at PC = 0x10 gives 0x10.
- Jump:
  - Stimulus: at PC = 0x14, Instruction = 0x08000010 and JMP = 1, PCSrc = 1.
  - Required: next PC = 0x40 (JMP wins).
- Jump-to-self halt:
  - Stimulus: at PC = 0x40, Instruction = 0x08000010 and JMP = 1.
  - Required: Halted = 1 and Running = 0 after the edge, PC stays 0x40, Instruction = 0, Instr_Count includes the jump.
- Out-of-range halt and restart:
  - Stimulus: Mem_Depth = 64, sequential run reaching PC = 0xFC.
  - Required: next PC = 0x100, Halted = 1, Instruction = 0, Load_En is ignored.
  - Stimulus: then pulse Start.
  - Required: PC = 0, Instr_Count = 0, Running = 1.
- Reset mid-run:
  - Stimulus: RST = 1 at PC = 0x8 in RUN.
  - Required: next edge gives PC = 0, state IDLE, Instr_Count = 0, all outputs at reset values, memory word 0 unchanged on reread after Start.
